// File: rtl/pipeline_ram_core.sv
// Four-stage IF/ID/MEM/WB load/store/add-immediate pipeline with private imem, register file and dmem.
// Optional feature macro PIPE_FWD_EN: forward ID/MEM (ADDI) and MEM/WB results into ID instead of interlocking.
module pipeline_ram_core #(
    parameter int DATA_W  = 64,
    parameter int REG_AW  = 3,
    parameter int IMEM_AW = 9,
    parameter int DMEM_AW = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               prog_we,
    input  logic [IMEM_AW-1:0] prog_addr,
    input  logic [31:0]        prog_wdata,
    input  logic               data_we,
    input  logic [DMEM_AW-1:0] data_addr,
    input  logic [DATA_W-1:0]  data_wdata,
    input  logic [REG_AW-1:0]  dbg_reg_addr,
    output logic [DATA_W-1:0]  dbg_reg_data,
    output logic [DATA_W-1:0]  dbg_mem_data,
    output logic [IMEM_AW-1:0] pc,
    output logic               halted,
    output logic [31:0]        retired
);
    localparam logic [3:0] OP_LOAD  = 4'd1;
    localparam logic [3:0] OP_STORE = 4'd2;
    localparam logic [3:0] OP_ADDI  = 4'd3;
    localparam logic [3:0] OP_HALT  = 4'd4;
    localparam int NREG = 1 << REG_AW;

    logic [31:0]       imem   [0:(1<<IMEM_AW)-1];
    logic [DATA_W-1:0] dmem   [0:(1<<DMEM_AW)-1];
    logic [DATA_W-1:0] regs_q [0:NREG-1];

    logic [IMEM_AW-1:0] pc_q;
    logic               halt_pending_q, halted_q;
    logic [31:0]        retired_q;

    logic               ifid_valid_q;
    logic [31:0]        ifid_instr_q;

    logic               idm_valid_q;
    logic [3:0]         idm_op_q;
    logic [REG_AW-1:0]  idm_rd_q;
    logic [DATA_W-1:0]  idm_sum_q, idm_sdata_q;

    logic               mwb_valid_q;
    logic [3:0]         mwb_op_q;
    logic [REG_AW-1:0]  mwb_rd_q;
    logic [DATA_W-1:0]  mwb_result_q;

    logic [3:0]         id_op;
    logic [REG_AW-1:0]  id_rd, id_rs;
    logic [DATA_W-1:0]  id_imm, rs_val, rd_val;
    logic               idm_wr, mwb_wr, idm_blocks, mwb_blocks;
    logic               rs_haz, rd_haz, stall, id_halt, fetch_off;
    logic               unused_ok;

    assign id_op  = ifid_instr_q[31:28];
    assign id_rd  = ifid_instr_q[24 +: REG_AW];
    assign id_rs  = ifid_instr_q[20 +: REG_AW];
    assign id_imm = {{(DATA_W-16){ifid_instr_q[15]}}, ifid_instr_q[15:0]};
    assign unused_ok = ^ifid_instr_q[27:16];

    // Only LOAD/ADDI to a nonzero register ever produce a value later stages must respect.
    assign idm_wr = idm_valid_q && (idm_op_q == OP_LOAD || idm_op_q == OP_ADDI) && (idm_rd_q != '0);
    assign mwb_wr = mwb_valid_q && (mwb_op_q == OP_LOAD || mwb_op_q == OP_ADDI) && (mwb_rd_q != '0);

`ifdef PIPE_FWD_EN
    assign idm_blocks = idm_wr && (idm_op_q == OP_LOAD);
    assign mwb_blocks = 1'b0;
`else
    assign idm_blocks = idm_wr;
    assign mwb_blocks = mwb_wr;
`endif

    assign rs_haz = (idm_blocks && idm_rd_q == id_rs) || (mwb_blocks && mwb_rd_q == id_rs);
    assign rd_haz = (id_op == OP_STORE) &&
                    ((idm_blocks && idm_rd_q == id_rd) || (mwb_blocks && mwb_rd_q == id_rd));
    assign stall     = ifid_valid_q && (rs_haz || rd_haz);
    assign id_halt   = ifid_valid_q && (id_op == OP_HALT);
    assign fetch_off = halt_pending_q || id_halt;

    // Write-first register file: the MEM/WB value is visible to ID in the same cycle.
    always_comb begin
        rs_val = regs_q[id_rs];
        rd_val = regs_q[id_rd];
        if (mwb_wr && mwb_rd_q == id_rs) rs_val = mwb_result_q;
        if (mwb_wr && mwb_rd_q == id_rd) rd_val = mwb_result_q;
`ifdef PIPE_FWD_EN
        if (idm_wr && idm_op_q == OP_ADDI && idm_rd_q == id_rs) rs_val = idm_sum_q;
        if (idm_wr && idm_op_q == OP_ADDI && idm_rd_q == id_rd) rd_val = idm_sum_q;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q           <= '0;
            halt_pending_q <= 1'b0;
            halted_q       <= 1'b0;
            retired_q      <= '0;
            ifid_valid_q   <= 1'b0;
            ifid_instr_q   <= '0;
            idm_valid_q    <= 1'b0;
            idm_op_q       <= '0;
            idm_rd_q       <= '0;
            idm_sum_q      <= '0;
            idm_sdata_q    <= '0;
            mwb_valid_q    <= 1'b0;
            mwb_op_q       <= '0;
            mwb_rd_q       <= '0;
            mwb_result_q   <= '0;
            for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
        end else begin
            if (!stall) begin
                if (fetch_off) begin
                    ifid_valid_q <= 1'b0;
                end else begin
                    ifid_valid_q <= 1'b1;
                    ifid_instr_q <= imem[pc_q];
                    pc_q         <= pc_q + IMEM_AW'(1);
                end
                if (id_halt) halt_pending_q <= 1'b1;
            end

            idm_valid_q <= ifid_valid_q && !stall;
            idm_op_q    <= id_op;
            idm_rd_q    <= id_rd;
            idm_sum_q   <= rs_val + id_imm;
            idm_sdata_q <= rd_val;

            mwb_valid_q  <= idm_valid_q;
            mwb_op_q     <= idm_op_q;
            mwb_rd_q     <= idm_rd_q;
            mwb_result_q <= (idm_op_q == OP_LOAD) ? dmem[idm_sum_q[DMEM_AW-1:0]] : idm_sum_q;

            if (mwb_wr) regs_q[mwb_rd_q] <= mwb_result_q;
            if (mwb_valid_q) retired_q <= retired_q + 32'd1;
            if (mwb_valid_q && mwb_op_q == OP_HALT) halted_q <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (prog_we) imem[prog_addr] <= prog_wdata;
    end

    // Pipeline store is written last so it wins a same-address collision with the loader.
    always_ff @(posedge clk) begin
        if (data_we) dmem[data_addr] <= data_wdata;
        if (idm_valid_q && idm_op_q == OP_STORE) dmem[idm_sum_q[DMEM_AW-1:0]] <= idm_sdata_q;
    end

    assign dbg_reg_data = regs_q[dbg_reg_addr];
    assign dbg_mem_data = dmem[data_addr];
    assign pc           = pc_q;
    assign halted       = halted_q;
    assign retired      = retired_q;
endmodule

// File: doc/pipeline_ram_core.md
# pipeline_ram_core

Parametrised four-stage (IF, ID, MEM, WB) load/store/add-immediate pipeline with private instruction memory, register file and data memory. It is the next generation of the lab pipeline-with-RAM datapath. It adds configurable widths and depths, a hardwired-zero register, hazard interlock with optional forwarding, HALT, and retire counting. Program and data are loaded through write ports, and state is observed through debug read ports, so benches never reach into hierarchy.

## Interface
- DATA_W, 64: register and data-memory word width
- REG_AW, 3: register address width (2^REG_AW registers, R0 reads zero)
- IMEM_AW, 9: instruction memory address width (32-bit words)
- DMEM_AW, 8: data memory address width (DATA_W words)
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- prog_we  in  1  write prog_wdata to imem[prog_addr] at clk edge
- prog_addr  in  IMEM_AW  imem write address
- prog_wdata  in  32  instruction word
- data_we  in  1  loader write to dmem (pipeline stores win on same-address collision)
- data_addr  in  DMEM_AW  loader dmem address, also debug read address
- data_wdata  in  DATA_W  loader data
- dbg_reg_addr  in  REG_AW  debug register select
- dbg_reg_data  out  DATA_W  combinational R[dbg_reg_addr]
- dbg_mem_data  out  DATA_W  combinational dmem[data_addr]
- pc  out  IMEM_AW  fetch PC
- halted  out  1  sticky, HALT has retired
- retired  out  32  count of non-bubble instructions written back

## Operation
- Instruction format:
  - [31:28] opcode
  - [27:24] rd, low REG_AW bits used
  - [23:20] rs, low REG_AW bits used
  - [15:0] imm, sign-extended to DATA_W
- Opcodes:
  - 0 NOP
  - 1 LOAD: rd ← dmem[R[rs]+imm]
  - 2 STORE: dmem[R[rs]+imm] ← R[rd]
  - 3 ADDI: rd ← R[rs]+imm
  - 4 HALT
  - 5–15: treated as NOP
- IF stage: the IF/ID register captures imem[pc] (asynchronous array read); pc increments modulo 2^IMEM_AW.
- ID stage:
  - Reads R[rs] and R[rd]. The register file is write-first: a same-cycle WB write is visible.
  - Computes sum = R[rs]+imm modulo 2^DATA_W.
  - Loads the ID/MEM register.
- MEM stage:
  - Data-memory address is sum[DMEM_AW-1:0], so it wraps.
  - STORE writes at the clock edge.
  - LOAD reads asynchronously into the MEM/WB register.
  - ADDI passes sum through.
- WB stage: writes rd when the instruction is LOAD or ADDI and rd≠0; retired increments for every non-bubble instruction, including NOP-class and HALT.
- Hazard: the ID instruction reads rs (all opcodes) and also rd (STORE). A hazard exists when a read register is nonzero and equals the rd of a LOAD/ADDI in ID/MEM or MEM/WB.
- Stall: pc and IF/ID hold, and a bubble enters ID/MEM.
- HALT in ID:
  - halt_pending is set; pc freezes and IF/ID loads a bubble thereafter.
  - HALT proceeds through the pipeline; halted sets when HALT is in WB.
- Reset clears: pc=0, IF/ID/ID-MEM/MEM-WB=bubble, registers=0, halted=0, retired=0, halt_pending=0. imem and dmem are not cleared.
- Load ports operate while rst is high.

## Timing
- With no hazards, one instruction retires per cycle. The first instruction at imem[0] writes back on the 4th rising edge after rst deasserts.
- Without forwarding: a dependent instruction immediately after its producer stalls 2 cycles; with one instruction between them, it stalls 1 cycle.
- Stall and bubble decisions are combinational from the current pipeline registers. They take effect at the same edge.
- Store followed by a load to the same address in the next instruction returns the stored value, because the store commits before the load reaches MEM.
- Reset mid-stall or mid-halt aborts everything immediately; in-flight WB writes are lost.
- prog_we while running: the write is visible to a fetch in the following cycle.

## Configuration
- PIPE_FWD_EN defined:
  - MEM/WB result forwards to the ID operand read, so the MEM/WB hazard is removed.
  - The ADDI sum held in ID/MEM forwards to ID, so an ADDI producer never stalls.
  - A LOAD in ID/MEM still causes a 1-cycle stall.
  - Forwarding priority: ID/MEM over MEM/WB over the register file.
- PIPE_FWD_EN undefined: interlock only, with stall counts as stated in Timing.

## Test plan
- Reset behaviour: hold rst 3 cycles while loading a program → pc=0, halted=0, retired=0, all dbg_reg_data=0. Release reset → pc increments by 1 per cycle.
- Basic program: ADDI R1,R0,5; ADDI R2,R0,7; STORE R2,[R1+0]; LOAD R3,[R0+5]; HALT → R1=5, R2=7, dmem[5]=7, R3=7, halted=1, retired=5.
- Back-to-back dependency: ADDI R1,R0,1; ADDI R1,R1,1 ×3; HALT → R1=4. Retire cycle count differs by exactly 6 stall cycles without PIPE_FWD_EN versus with it.
- Load-use: LOAD R4,[R0+2] with dmem[2]=0x1234, then ADDI R5,R4,1 → R5=0x1235. Stall is 2 cycles without forwarding and 1 cycle with it.
- Zero register and wrap: ADDI R0,R0,9 → R0 stays 0 and causes no stall. STORE to address 2^DMEM_AW+3 → dmem[3] is written.
- Async reset mid-program: assert rst between edges while a LOAD is in MEM → outputs clear immediately and the register file is zero. After release, execution restarts from pc=0.
